btb_tag_hash_unit: RTL and testbench

- Computes the branch target buffer (BTB) tag from a fetch PC and the current address-space ID (ASID).
- The hash XOR-folds two PC tag fields with the low ASID bits.
- Sits in the front-end next to the BTB array; the combinational tag feeds same-cycle BTB compare and write.
- An optional registered copy with a valid bit serves the next pipeline stage.

---
 rtl/btb_tag_hash_unit.sv | 59 +++++
 tb/tb_btb_tag_hash_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/btb_tag_hash_unit.sv
// BTB tag hash: XOR-folds NUM_PC_FOLDS PC tag fields with the low ASID bits.
// Latency: tag is combinational (0 cycles); tag_q/valid_q are one cycle later. No backpressure.
module btb_tag_hash_unit #(
    parameter int BTB_TAG_WIDTH = 6,
    parameter int PC_WIDTH      = 32,
    parameter int ASID_WIDTH    = 9,
    parameter int TAG_LSB       = 12,
    parameter int NUM_PC_FOLDS  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [PC_WIDTH-1:0]      PC,
    input  logic [ASID_WIDTH-1:0]    ASID,
    input  logic                     valid_in,
    output logic [BTB_TAG_WIDTH-1:0] tag,
    output logic [BTB_TAG_WIDTH-1:0] tag_q,
    output logic                     valid_q
);

    if (TAG_LSB + NUM_PC_FOLDS * BTB_TAG_WIDTH > PC_WIDTH) begin : g_err_pc_range
        $error("btb_tag_hash_unit: PC fold fields extend beyond PC_WIDTH");
    end

    if (BTB_TAG_WIDTH > ASID_WIDTH) begin : g_err_asid_range
        $error("btb_tag_hash_unit: BTB_TAG_WIDTH exceeds ASID_WIDTH");
    end

    logic [BTB_TAG_WIDTH-1:0] w_tag;
    logic [BTB_TAG_WIDTH-1:0] r_tag_q;
    logic                     r_valid_q;
    logic                     w_unused_bits;

    always_comb begin
        w_tag = ASID[BTB_TAG_WIDTH-1:0];
        for (int k = 0; k < NUM_PC_FOLDS; k++) begin
            w_tag = w_tag ^ PC[TAG_LSB + k*BTB_TAG_WIDTH +: BTB_TAG_WIDTH];
        end
    end

    // Offset, set-index, upper PC and high ASID bits are deliberately not hashed.
    assign w_unused_bits = ^{PC, ASID};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tag_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= valid_in;
            if (valid_in) begin
                r_tag_q <= w_tag;
            end
        end
    end

    assign tag     = w_tag;
    assign tag_q   = r_tag_q;
    assign valid_q = r_valid_q;

endmodule

// File: tb/tb_btb_tag_hash_unit.sv
// Scoreboard bench for btb_tag_hash_unit: stimulus pushes expectations, a negedge monitor checks them.
module tb_btb_tag_hash_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic [8:0]  ASID;
    logic        valid_in;
    logic [5:0]  tag;
    logic [5:0]  tag_q;
    logic        valid_q;

    int tests;
    int fails;

    logic [5:0] q_comb[$];
    logic [6:0] q_reg[$];

    logic [5:0] m_tag_q;
    logic       m_valid_q;

    btb_tag_hash_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .PC       (PC),
        .ASID     (ASID),
        .valid_in (valid_in),
        .tag      (tag),
        .tag_q    (tag_q),
        .valid_q  (valid_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [5:0] ref_tag(input logic [31:0] pc, input logic [8:0] asid);
        return pc[17:12] ^ pc[23:18] ^ asid[5:0];
    endfunction

    // Drive one cycle of inputs after a posedge, then record the expected registered state after the next edge.
    task automatic step(input logic rst, input logic vin, input logic [31:0] pc,
                        input logic [8:0] asid, input logic [5:0] exp_tag);
        RST      = rst;
        valid_in = vin;
        PC       = pc;
        ASID     = asid;
        q_comb.push_back(exp_tag);
        @(posedge CLK);
        if (rst) begin
            m_tag_q   = 6'd0;
            m_valid_q = 1'b0;
        end else begin
            m_valid_q = vin;
            if (vin) m_tag_q = exp_tag;
        end
        q_reg.push_back({m_valid_q, m_tag_q});
        #1;
    endtask

    always @(negedge CLK) begin
        logic [5:0] e_tag;
        logic [6:0] e_reg;
        if (q_comb.size() > 0) begin
            e_tag = q_comb.pop_front();
            tests++;
            if (tag !== e_tag) begin
                fails++;
                $display("FAIL comb_tag: PC=%h ASID=%h got %b expected %b", PC, ASID, tag, e_tag);
            end
        end
        if (q_reg.size() > 0) begin
            e_reg = q_reg.pop_front();
            tests++;
            if ({valid_q, tag_q} !== e_reg) begin
                fails++;
                $display("FAIL reg_out: got valid_q=%b tag_q=%b expected valid_q=%b tag_q=%b",
                         valid_q, tag_q, e_reg[6], e_reg[5:0]);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        logic [8:0]  asid;
        logic [2:0]  sel;

        tests     = 0;
        fails     = 0;
        m_tag_q   = 6'd0;
        m_valid_q = 1'b0;
        RST       = 1'b1;
        valid_in  = 1'b0;
        PC        = 32'd0;
        ASID      = 9'd0;
        @(posedge CLK);
        #1;

        // Reset state, including reset winning over valid_in.
        step(1'b1, 1'b0, 32'h0000_0000, 9'h000, 6'b000000);
        step(1'b1, 1'b1, 32'h0000_0000, 9'h000, 6'b000000);

        // All eight all-0/all-1 combinations of PC[23:18], PC[17:12], ASID[5:0].
        for (int i = 0; i < 8; i++) begin
            sel  = 3'(i);
            pc   = 32'd0;
            asid = 9'd0;
            if (sel[2]) pc[23:18] = 6'h3F;
            if (sel[1]) pc[17:12] = 6'h3F;
            if (sel[0]) asid[5:0] = 6'h3F;
            step(1'b0, 1'b0, pc, asid, (^sel) ? 6'b111111 : 6'b000000);
        end

        // Ignored bits.
        step(1'b0, 1'b0, 32'hFF00_0FFF, 9'h1C0, 6'b000000);
        step(1'b0, 1'b0, 32'h0004_1000, 9'h000, 6'b000000);
        step(1'b0, 1'b0, 32'h0004_1000, 9'h001, 6'b000001);

        // Registered capture, then hold when valid_in drops.
        step(1'b0, 1'b1, 32'h00FC_0000, 9'h000, 6'b111111);
        step(1'b0, 1'b0, 32'h0000_1000, 9'h000, 6'b000001);

        // Reset mid-stream with valid_in high.
        step(1'b0, 1'b1, 32'h00FC_0000, 9'h000, 6'b111111);
        step(1'b1, 1'b1, 32'h0000_2000, 9'h003, 6'b000001);
        step(1'b0, 1'b1, 32'h00AB_C123, 9'h155, 6'b000011);

        // Random sweep.
        for (int i = 0; i < 1000; i++) begin
            pc   = $urandom;
            asid = 9'($urandom);
            step(1'b0, 1'($urandom_range(0, 1)), pc, asid, ref_tag(pc, asid));
        end

        @(negedge CLK);
        #1;
        tests++;
        if (q_comb.size() != 0 || q_reg.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending entries expected 0/0", q_comb.size(), q_reg.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
